mtr_pwm_drv: RTL

//  Back end of the signed speed interface: consumes lft_spd/rght_spd (12b signed duty,
//  0x800..0x7FF) and drives forward/reverse PWM pins of both H-bridge motor channels.
//  A free-running period counter generates PWM. Duty/direction are double-buffered at

---
 rtl/mtr_pwm_drv.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv -- dual-channel H-bridge PWM back end.
//
// Turns the signed 12-bit speed requests (lft_spd / rght_spd, 0x800..0x7FF) into
// forward/reverse PWM pins for two motor channels. A free-running CNT_W-bit counter
// defines the PWM period (2**CNT_W clocks). Each channel latches its request once per
// period (when the counter is all-ones), so pins only change duty/direction on period
// boundaries. Every period starts with DEADTIME cycles of both pins low, and a
// direction reversal costs one full coast period with both pins low.
// pwm_synch pulses for one cycle at the start of each period (ADC alignment).
//
// Optional feature (compile-time macro TOO_FAST_CLAMP_EN):
//   defined   -> while too_fast is high at the load cycle, the latched magnitude is
//                limited to CLAMP_DTY for the whole following period.
//   undefined -> too_fast is ignored; magnitude is never clamped.
//
// Ports:
//   clk            in  system clock
//   rst            in  synchronous active-high reset
//   lft_spd        in  [11:0] signed left duty request
//   rght_spd       in  [11:0] signed right duty request
//   too_fast       in  overspeed flag (only used with TOO_FAST_CLAMP_EN)
//   PWM_frwrd_lft  out left forward drive
//   PWM_rev_lft    out left reverse drive
//   PWM_frwrd_rght out right forward drive
//   PWM_rev_rght   out right reverse drive
//   pwm_synch      out one-cycle pulse at the first cycle of each period
// All outputs are registered: one clock of latency from the counter/shadow state.

// ---------------------------------------------------------------------------
// mtr_pwm_chan -- one H-bridge channel: request decode, shadow registers,
// reversal FSM and registered pin drive.
//   clk, rst   clock / synchronous active-high reset
//   cnt        shared period counter
//   ld         period boundary strobe (cnt all-ones)
//   spd        signed duty request
//   clamp      limit latched magnitude to CLAMP_DTY at this load
//   pwm_frwrd  forward pin (registered)
//   pwm_rev    reverse pin (registered)
// ---------------------------------------------------------------------------
module mtr_pwm_chan #(
  parameter int               CNT_W     = 11,
  parameter int               DEADTIME  = 8,
  parameter logic [CNT_W-1:0] CLAMP_DTY = 11'h600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             ld,
  input  logic [11:0]      spd,
  input  logic             clamp,
  output logic             pwm_frwrd,
  output logic             pwm_rev
);

  typedef enum logic {RUN = 1'b0, COAST = 1'b1} st_t;

  localparam logic [CNT_W-1:0] DT = CNT_W'(DEADTIME);

  st_t              st;
  logic             dir;      // active direction, 1 = reverse
  logic [CNT_W-1:0] mag;      // active magnitude
  logic [11:0]      abs_spd;
  logic [CNT_W-1:0] req_mag;
  logic [CNT_W-1:0] ld_mag;
  logic             req_dir;
  logic             pulse;

  // Two's-complement magnitude. Only 0x800 leaves bit 11 set after negation,
  // and that one value saturates to full scale.
  assign abs_spd = spd[11] ? (~spd + 12'd1) : spd;
  assign req_mag = abs_spd[11] ? {CNT_W{1'b1}} : abs_spd[CNT_W-1:0];
  assign req_dir = spd[11];
  assign ld_mag  = (clamp && (req_mag > CLAMP_DTY)) ? CLAMP_DTY : req_mag;

  // Dead time at period start; pulse ends when the counter reaches the magnitude.
  assign pulse = (st == RUN) && (cnt >= DT) && (cnt < mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      dir       <= 1'b0;
      mag       <= '0;
      pwm_frwrd <= 1'b0;
      pwm_rev   <= 1'b0;
    end else begin
      if (ld) begin
        case (st)
          // A nonzero request in the opposite direction first parks the bridge
          // for a full period; the active direction is kept until then.
          RUN: begin
            if ((req_dir != dir) && (ld_mag != '0)) begin
              st <= COAST;
            end else begin
              dir <= req_dir;
              mag <= ld_mag;
            end
          end
          // Whatever is requested at the end of the coast period is taken as-is,
          // so flipping back to the old direction resumes without another coast.
          COAST: begin
            dir <= req_dir;
            mag <= ld_mag;
            st  <= RUN;
          end
          default: st <= RUN;
        endcase
      end
      // Direction gating keeps the two pins mutually exclusive.
      pwm_frwrd <= pulse & ~dir;
      pwm_rev   <= pulse &  dir;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// mtr_pwm_drv -- top: period counter, sync pulse and two channel instances.
// ---------------------------------------------------------------------------
module mtr_pwm_drv #(
  parameter int               CNT_W     = 11,
  parameter int               DEADTIME  = 8,
  parameter logic [CNT_W-1:0] CLAMP_DTY = 11'h600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        too_fast,
  output logic        PWM_frwrd_lft,
  output logic        PWM_rev_lft,
  output logic        PWM_frwrd_rght,
  output logic        PWM_rev_rght,
  output logic        pwm_synch
);

  localparam int NUM_CH = 2;   // lane 0 = left, lane 1 = right

  logic [CNT_W-1:0]        cnt;
  logic                    ld;
  logic                    clamp;
  logic [NUM_CH-1:0][11:0] spd;
  logic [NUM_CH-1:0]       frwrd;
  logic [NUM_CH-1:0]       rev;

  // Requests are latched in the last cycle of the period so the new shadow
  // values are live from cnt==0 onward.
  assign ld  = &cnt;
  assign spd = {rght_spd, lft_spd};

`ifdef TOO_FAST_CLAMP_EN
  assign clamp = too_fast;
`else
  logic unused_too_fast;
  assign unused_too_fast = too_fast;
  assign clamp           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pwm_synch <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      pwm_synch <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mtr_pwm_chan #(
      .CNT_W    (CNT_W),
      .DEADTIME (DEADTIME),
      .CLAMP_DTY(CLAMP_DTY)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt),
      .ld       (ld),
      .spd      (spd[i]),
      .clamp    (clamp),
      .pwm_frwrd(frwrd[i]),
      .pwm_rev  (rev[i])
    );
  end

  assign PWM_frwrd_lft  = frwrd[0];
  assign PWM_rev_lft    = rev[0];
  assign PWM_frwrd_rght = frwrd[1];
  assign PWM_rev_rght   = rev[1];

endmodule
